// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback / register-file slice: datapath width,
// register index type and the encoding of the writeback result select.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_idx_t;

  // Writeback result source; encodings 3'b101..3'b111 are unused and select zero.
  typedef enum logic [2:0] {
    RES_ALU   = 3'b000,
    RES_MEM   = 3'b001,
    RES_PC4   = 3'b010,
    RES_IMM   = 3'b011,
    RES_PCIMM = 3'b100
  } result_src_e;

endpackage

// File: rtl/writeback_result_mux.sv
// Writeback result select: picks the value to commit from the W-stage operands.
// Unused select encodings produce zero so the result never carries X.
module writeback_result_mux #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      result_src,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] data_mem_output,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] ext_imm,
  input  logic [XLEN-1:0] pc_plus_ext_imm,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  // Pure combinational select on the decoded result source.
  always_comb begin
    result = '0;
    case (result_src_e'(result_src))
      RES_ALU:   result = alu_result;
      RES_MEM:   result = data_mem_output;
      RES_PC4:   result = pc_plus4;
      RES_IMM:   result = ext_imm;
      RES_PCIMM: result = pc_plus_ext_imm;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage and integer register file. Selects the W-stage result,
// commits it to the array, serves the two decode read ports with zero-latency
// write-through bypass and counts retired register writes for debug.
//
// Handshake: reg_write_W acts as a valid with no ready; a presented write is
// always accepted on the next posedge CLK (unless RESET is high), and the
// bypass makes it visible at the read ports in the presenting cycle.
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [2:0]      result_src_W,
  input  logic            reg_write_W,
  input  logic [AW-1:0]   rd_W,
  input  logic [XLEN-1:0] alu_result_W,
  input  logic [XLEN-1:0] data_mem_output_W,
  input  logic [XLEN-1:0] pc_plus4_W,
  input  logic [XLEN-1:0] ext_imm_W,
  input  logic [XLEN-1:0] pc_plus_ext_imm_W,
  input  logic [AW-1:0]   a1_D,
  input  logic [AW-1:0]   a2_D,
  output logic [XLEN-1:0] rd1_D,
  output logic [XLEN-1:0] rd2_D,
  output logic [XLEN-1:0] result_W,
  output logic [31:0]     commit_count
);
  import riscv_pkg::*;

  if (NREGS > (1 << AW)) begin : g_bad_cfg
    $error("writeback_regfile: NREGS does not fit in AW index bits");
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic [31:0]     commit_cnt_q;
  logic [XLEN-1:0] result;
  logic            wr_en;

  // Indices at or above NREGS address nothing: reads give 0, writes drop.
  function automatic logic idx_in_range(input logic [AW-1:0] idx);
    return ({{(32-AW){1'b0}}, idx} < 32'(NREGS));
  endfunction

  writeback_result_mux #(.XLEN(XLEN)) u_result_mux (
    .result_src      (result_src_W),
    .alu_result      (alu_result_W),
    .data_mem_output (data_mem_output_W),
    .pc_plus4        (pc_plus4_W),
    .ext_imm         (ext_imm_W),
    .pc_plus_ext_imm (pc_plus_ext_imm_W),
    .result          (result)
  );

  assign result_W     = result;
  assign commit_count = commit_cnt_q;

  // A commit retires only for a real, in-range destination; x0 is hardwired.
  assign wr_en = reg_write_W && (rd_W != '0) && idx_in_range(rd_W);

  // Register array: cleared on reset, written with the selected result on commit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_W] <= result;
    end
  end

  // Debug counter of retired register writes; wraps naturally at 2**32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      commit_cnt_q <= '0;
    end else if (wr_en) begin
      commit_cnt_q <= commit_cnt_q + 32'd1;
    end
  end

  // Read port 1: x0 and out-of-range read 0, a matching write bypasses the array.
  always_comb begin
    rd1_D = '0;
    if ((a1_D != '0) && idx_in_range(a1_D)) begin
      if (reg_write_W && (rd_W == a1_D)) rd1_D = result;
      else                               rd1_D = regs_q[a1_D];
    end
  end

  // Read port 2: same rules as port 1, bypassing independently.
  always_comb begin
    rd2_D = '0;
    if ((a2_D != '0) && idx_in_range(a2_D)) begin
      if (reg_write_W && (rd_W == a2_D)) rd2_D = result;
      else                               rd2_D = regs_q[a2_D];
    end
  end

endmodule
